// File: rtl/inv_mix_columns_seq_if.sv
// Handshake bundle for the sequential InvMixColumns unit.
// Upstream accept (i_valid/o_ready), downstream offer (o_valid/i_ready), plus status.
interface inv_mix_columns_seq_if;
  logic         i_valid;
  logic         o_ready;
  logic [127:0] i_data;
  logic         o_valid;
  logic         i_ready;
  logic [127:0] o_data;
  logic         o_busy;

  modport slave  (input  i_valid, i_data, i_ready,
                  output o_ready, o_valid, o_data, o_busy);
  modport master (output i_valid, i_data, i_ready,
                  input  o_ready, o_valid, o_data, o_busy);
endinterface

// File: rtl/inv_mix_columns_seq.sv
// AES InvMixColumns, one 32-bit column per clock through a shared GF(2^8) datapath.
// Result is held in DONE until downstream accepts it.
//
// state | meaning
// IDLE  | o_ready high, waiting for an input state
// CALC  | one column per cycle, counter selects column 0..3
// DONE  | o_valid high, result held until i_ready
module inv_mix_columns_seq (
  input  logic                  clk,
  input  logic                  n_rst,
  inv_mix_columns_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t       state_q;
  logic [1:0]   cnt_q;
  logic [127:0] in_q;
  logic [127:0] out_q;
  logic         valid_q;
  logic         ready_q;
  logic         busy_q;
  logic [31:0]  col_in;
  logic [31:0]  col_d;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m09(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction

  function automatic logic [7:0] m0b(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction

  function automatic logic [7:0] m0d(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction

  function automatic logic [7:0] m0e(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  always_comb begin
    col_in = 32'h0;
    case (cnt_q)
      2'd0: col_in = in_q[127:96];
      2'd1: col_in = in_q[95:64];
      2'd2: col_in = in_q[63:32];
      2'd3: col_in = in_q[31:0];
      default: col_in = 32'h0;
    endcase
    col_d[31:24] = m0e(col_in[31:24]) ^ m0b(col_in[23:16]) ^ m0d(col_in[15:8]) ^ m09(col_in[7:0]);
    col_d[23:16] = m09(col_in[31:24]) ^ m0e(col_in[23:16]) ^ m0b(col_in[15:8]) ^ m0d(col_in[7:0]);
    col_d[15:8]  = m0d(col_in[31:24]) ^ m09(col_in[23:16]) ^ m0e(col_in[15:8]) ^ m0b(col_in[7:0]);
    col_d[7:0]   = m0b(col_in[31:24]) ^ m0d(col_in[23:16]) ^ m09(col_in[15:8]) ^ m0e(col_in[7:0]);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      in_q    <= 128'h0;
      out_q   <= 128'h0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid) begin
            in_q    <= bus.i_data;
            cnt_q   <= 2'd0;
            state_q <= CALC;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        CALC: begin
          case (cnt_q)
            2'd0: out_q[127:96] <= col_d;
            2'd1: out_q[95:64]  <= col_d;
            2'd2: out_q[63:32]  <= col_d;
            2'd3: out_q[31:0]   <= col_d;
            default: ;
          endcase
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_data  = out_q;
  assign bus.o_busy  = busy_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed and round-trip checks for inv_mix_columns_seq.
module tb_inv_mix_columns_seq;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  inv_mix_columns_seq_if bus ();
  inv_mix_columns_seq dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Generic shift-and-add GF(2^8) multiply, independent of the DUT's fixed-coefficient chains.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_fwd(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      r[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return r;
  endfunction

  // Called at posedge+1 with the DUT idle; leaves it idle again.
  task automatic run_one(input logic [127:0] din, input logic [127:0] exp, input string tag);
    int lat;
    check({tag, " ready_idle"}, {127'h0, bus.o_ready}, 128'h1);
    bus.i_data  = din;
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    check({tag, " busy"}, {127'h0, bus.o_busy}, 128'h1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.o_valid) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, 128'(lat), 128'd4);
    check({tag, " data"}, bus.o_data, exp);
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    check({tag, " valid_drop"}, {127'h0, bus.o_valid}, 128'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] orig;
    logic [127:0] held;
    bit got_a, cap2, got_b, seen_busy;
    int acc_edge;

    vecs[0] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6};
    vecs[1] = '{128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, 128'hd4d4d4d5_2d26314c_00000000_ffffffff};
    vecs[2] = '{128'h0, 128'h0};
    vecs[3] = '{128'hffffffff_ffffffff_ffffffff_ffffffff, 128'hffffffff_ffffffff_ffffffff_ffffffff};

    n_rst = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_data  = 128'h0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    check("rst o_ready", {127'h0, bus.o_ready}, 128'h1);
    check("rst o_valid", {127'h0, bus.o_valid}, 128'h0);
    check("rst o_busy",  {127'h0, bus.o_busy},  128'h0);
    check("rst o_data",  bus.o_data, 128'h0);

    for (int i = 0; i < 4; i++)
      run_one(vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i));

    // Reset mid-CALC: o_data holds a prior non-zero result first.
    run_one(vecs[0].din, vecs[0].exp, "pre_rst");
    bus.i_data  = vecs[1].din;
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b0;
    #1;
    check("midrst o_valid", {127'h0, bus.o_valid}, 128'h0);
    check("midrst o_ready", {127'h0, bus.o_ready}, 128'h1);
    check("midrst o_busy",  {127'h0, bus.o_busy},  128'h0);
    check("midrst o_data",  bus.o_data, 128'h0);
    @(posedge clk); #1 n_rst = 1'b1;
    run_one(vecs[1].din, vecs[1].exp, "post_rst");

    // Backpressure in DONE with churning upstream inputs.
    bus.i_data  = vecs[0].din;
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    for (int k = 0; k < 20 && !bus.o_valid; k++) begin
      @(posedge clk); #1;
    end
    check("bp reach_done", {127'h0, bus.o_valid}, 128'h1);
    held = bus.o_data;
    check("bp data", held, vecs[0].exp);
    for (int k = 0; k < 10; k++) begin
      bus.i_valid = k[0];
      bus.i_data  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      check($sformatf("bp%0d valid", k), {127'h0, bus.o_valid}, 128'h1);
      check($sformatf("bp%0d ready", k), {127'h0, bus.o_ready}, 128'h0);
      check($sformatf("bp%0d data", k), bus.o_data, vecs[0].exp);
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    check("bp release ready", {127'h0, bus.o_ready}, 128'h1);
    check("bp release valid", {127'h0, bus.o_valid}, 128'h0);

    // Back-to-back streaming with both handshakes held high.
    got_a = 0; cap2 = 0; got_b = 0; seen_busy = 0; acc_edge = -1;
    bus.i_data  = vecs[0].din;
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (!seen_busy && bus.o_busy) begin
        seen_busy = 1;
        bus.i_data = vecs[1].din;
      end
      if (bus.o_valid && !got_a) begin
        got_a = 1;
        acc_edge = cyc + 1;
        check("b2b first data", bus.o_data, vecs[0].exp);
      end else if (got_a && !cap2 && bus.o_busy) begin
        cap2 = 1;
        check("b2b second capture edge", 128'(cyc), 128'(acc_edge + 1));
      end else if (cap2 && bus.o_valid) begin
        got_b = 1;
        check("b2b second data", bus.o_data, vecs[1].exp);
        bus.i_valid = 1'b0;
        break;
      end
    end
    check("b2b completed", {127'h0, got_b}, 128'h1);
    bus.i_valid = 1'b0;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    check("b2b final idle", {127'h0, bus.o_ready}, 128'h1);

    for (int n = 0; n < 100; n++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      run_one(mix_fwd(orig), orig, $sformatf("rt%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
